// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the memory-port arbiter.
package mem_arb_pkg;

  typedef enum logic {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

  localparam logic [31:0] ARB_ERR_RDATA = 32'h0;

endpackage

// File: rtl/mem_port_arbiter_rr_arbiter.sv
// Combinational round-robin picker: first requester after last_grant_i, wrapping.
module rr_arbiter #(
  parameter int N_MASTERS = 2
) (
  input  logic [N_MASTERS-1:0]         req_i,
  input  logic [$clog2(N_MASTERS)-1:0] last_grant_i,
  output logic [$clog2(N_MASTERS)-1:0] winner_o,
  output logic                         valid_o
);

  localparam int GW = $clog2(N_MASTERS);

  logic [GW-1:0] idx;

  // Scan from farthest to nearest so the nearest requester is the last write.
  always_comb begin
    winner_o = '0;
    valid_o  = 1'b0;
    idx      = '0;
    for (int k = N_MASTERS; k >= 1; k--) begin
      idx = GW'((int'(last_grant_i) + k) % N_MASTERS);
      if (req_i[idx]) begin
        winner_o = idx;
        valid_o  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between N requesters,
// with a latched request and a watchdog that forces an error completion.
//
//   state    | meaning
//   ARB_IDLE | no transaction; arbitrate live requests each cycle
//   ARB_BUSY | latched request on memory side; wait for ready or timeout
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int N_MASTERS = 2,
  parameter int TIMEOUT   = 255
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [N_MASTERS-1:0]        m_req_i,
  input  logic [N_MASTERS-1:0]        m_we_i,
  input  logic [N_MASTERS-1:0][3:0]   m_be_i,
  input  logic [N_MASTERS-1:0][31:0]  m_addr_i,
  input  logic [N_MASTERS-1:0][31:0]  m_wd_i,
  output logic [31:0]                 m_rd_o,
  output logic [N_MASTERS-1:0]        m_ready_o,
  output logic                        m_err_o,
  output logic                        mem_req_o,
  output logic                        mem_we_o,
  output logic [3:0]                  mem_be_o,
  output logic [31:0]                 mem_addr_o,
  output logic [31:0]                 mem_wd_o,
  input  logic [31:0]                 mem_rd_i,
  input  logic                        mem_ready_i,
  output logic                        busy_o
);

  localparam int GW = $clog2(N_MASTERS);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] last_grant_q, last_grant_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [3:0]    be_q, be_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;

  logic [GW-1:0] pick;
  logic          pick_valid;
  logic          timeout_hit;

  rr_arbiter #(.N_MASTERS(N_MASTERS)) u_rr (
    .req_i        (m_req_i),
    .last_grant_i (last_grant_q),
    .winner_o     (pick),
    .valid_o      (pick_valid)
  );

  assign timeout_hit = (cnt_q == CNT_LAST);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GW'(N_MASTERS - 1);
      cnt_q        <= '0;
      we_q         <= 1'b0;
      be_q         <= '0;
      addr_q       <= '0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      be_q         <= be_d;
      addr_q       <= addr_d;
      wd_q         <= wd_d;
    end
  end

  // The current grant is always the most recent winner, so last_grant_q doubles as it.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    be_d         = be_q;
    addr_d       = addr_q;
    wd_d         = wd_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_valid) begin
          state_d      = ARB_BUSY;
          last_grant_d = pick;
          cnt_d        = '0;
          we_d         = m_we_i[pick];
          be_d         = m_be_i[pick];
          addr_d       = m_addr_i[pick];
          wd_d         = m_wd_i[pick];
        end
      end
      ARB_BUSY: begin
        if (mem_ready_i || timeout_hit) begin
          state_d = ARB_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_comb begin
    m_rd_o     = '0;
    m_ready_o  = '0;
    m_err_o    = 1'b0;
    mem_req_o  = 1'b0;
    mem_we_o   = 1'b0;
    mem_be_o   = '0;
    mem_addr_o = '0;
    mem_wd_o   = '0;
    busy_o     = 1'b0;
    if (state_q == ARB_BUSY) begin
      mem_req_o  = 1'b1;
      busy_o     = 1'b1;
      mem_we_o   = we_q;
      mem_be_o   = be_q;
      mem_addr_o = addr_q;
      mem_wd_o   = wd_q;
      if (mem_ready_i) begin
        m_ready_o[last_grant_q] = 1'b1;
        m_rd_o                  = mem_rd_i;
      end else if (timeout_hit) begin
        m_ready_o[last_grant_q] = 1'b1;
        m_err_o                 = 1'b1;
        m_rd_o                  = ARB_ERR_RDATA;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios plus a
// randomized run against a transaction-level reference model.
module tb_mem_port_arbiter;

  localparam int NM = 4;
  localparam int TO = 4;

  logic                 clk_i = 1'b0;
  logic                 rst_ni;
  logic [NM-1:0]        m_req_i;
  logic [NM-1:0]        m_we_i;
  logic [NM-1:0][3:0]   m_be_i;
  logic [NM-1:0][31:0]  m_addr_i;
  logic [NM-1:0][31:0]  m_wd_i;
  logic [31:0]          m_rd_o;
  logic [NM-1:0]        m_ready_o;
  logic                 m_err_o;
  logic                 mem_req_o;
  logic                 mem_we_o;
  logic [3:0]           mem_be_o;
  logic [31:0]          mem_addr_o;
  logic [31:0]          mem_wd_o;
  logic [31:0]          mem_rd_i;
  logic                 mem_ready_i;
  logic                 busy_o;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.N_MASTERS(NM), .TIMEOUT(TO)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .m_req_i     (m_req_i),
    .m_we_i      (m_we_i),
    .m_be_i      (m_be_i),
    .m_addr_i    (m_addr_i),
    .m_wd_i      (m_wd_i),
    .m_rd_o      (m_rd_o),
    .m_ready_o   (m_ready_o),
    .m_err_o     (m_err_o),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_be_o    (mem_be_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wd_o    (mem_wd_o),
    .mem_rd_i    (mem_rd_i),
    .mem_ready_i (mem_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic idle_inputs();
    m_req_i     = '0;
    m_we_i      = '0;
    m_be_i      = '0;
    m_addr_i    = '0;
    m_wd_i      = '0;
    mem_rd_i    = '0;
    mem_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    idle_inputs();
    cyc();
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    idle_inputs();
    #2;
    n_checks++;
    if ({m_rd_o, m_ready_o, m_err_o, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, busy_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got req=%b busy=%b ready=%b addr=%h expected all zero", mem_req_o, busy_o, m_ready_o, mem_addr_o);
    end
    m_req_i     = '1;
    m_addr_i[0] = 32'h1234;
    mem_ready_i = 1'b1;
    cyc();
    settle();
    n_checks++;
    if ({mem_req_o, busy_o, m_ready_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_hold: got req=%b busy=%b ready=%b expected 0 0 0", mem_req_o, busy_o, m_ready_o);
    end
    idle_inputs();
    cyc();
    rst_ni = 1'b1;
  endtask

  task automatic test_single_read();
    do_reset();
    m_req_i[0]  = 1'b1;
    m_addr_i[0] = 32'h100;
    cyc();
    settle();
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || mem_we_o !== 1'b0 || m_ready_o !== '0 || busy_o !== 1'b1) begin
      n_fail++;
      $display("FAIL read_issue: got req=%b addr=%h we=%b ready=%b busy=%b expected 1 00000100 0 0000 1", mem_req_o, mem_addr_o, mem_we_o, m_ready_o, busy_o);
    end
    cyc();
    settle();
    n_checks++;
    if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100 || m_ready_o !== '0) begin
      n_fail++;
      $display("FAIL read_wait: got req=%b addr=%h ready=%b expected 1 00000100 0000", mem_req_o, mem_addr_o, m_ready_o);
    end
    cyc();
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'hCAFEBABE;
    settle();
    n_checks++;
    if (m_ready_o !== 4'b0001 || m_rd_o !== 32'hCAFEBABE || m_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL read_done: got ready=%b rd=%h err=%b expected 0001 cafebabe 0", m_ready_o, m_rd_o, m_err_o);
    end
    cyc();
    idle_inputs();
    settle();
    n_checks++;
    if ({mem_req_o, busy_o, m_ready_o, m_rd_o, mem_addr_o} !== '0) begin
      n_fail++;
      $display("FAIL read_idle: got req=%b busy=%b ready=%b rd=%h addr=%h expected zeros", mem_req_o, busy_o, m_ready_o, m_rd_o, mem_addr_o);
    end
  endtask

  task automatic test_back_to_back();
    logic [NM-1:0] er;
    int g;
    do_reset();
    m_req_i     = 4'b0011;
    m_addr_i[0] = 32'h10;
    m_addr_i[1] = 32'h14;
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'h0BAD_F00D;
    for (int k = 0; k < 8; k++) begin
      cyc();
      settle();
      n_checks++;
      if (k % 2 == 0) begin
        g  = (k / 2) % 2;
        er = '0;
        er[g] = 1'b1;
        if (m_ready_o !== er || mem_addr_o !== m_addr_i[g] || busy_o !== 1'b1 || m_rd_o !== 32'h0BAD_F00D) begin
          n_fail++;
          $display("FAIL b2b_grant k=%0d: got ready=%b addr=%h busy=%b expected ready=%b addr=%h busy=1", k, m_ready_o, mem_addr_o, busy_o, er, m_addr_i[g]);
        end
      end else begin
        if (m_ready_o !== '0 || busy_o !== 1'b0 || mem_req_o !== 1'b0) begin
          n_fail++;
          $display("FAIL b2b_idle k=%0d: got ready=%b busy=%b req=%b expected 0000 0 0", k, m_ready_o, busy_o, mem_req_o);
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_write_hold();
    do_reset();
    m_req_i[1]  = 1'b1;
    m_we_i[1]   = 1'b1;
    m_be_i[1]   = 4'b0100;
    m_addr_i[1] = 32'h20;
    m_wd_i[1]   = 32'h00AA0000;
    for (int c = 1; c <= 3; c++) begin
      cyc();
      if (c == 1) begin
        m_addr_i[1] = 32'h99;
        m_be_i[1]   = 4'b1111;
        m_wd_i[1]   = 32'hFFFF_FFFF;
        m_we_i[1]   = 1'b0;
      end
      if (c == 3) mem_ready_i = 1'b1;
      settle();
      n_checks++;
      if (mem_we_o !== 1'b1 || mem_be_o !== 4'b0100 || mem_addr_o !== 32'h20 || mem_wd_o !== 32'h00AA0000) begin
        n_fail++;
        $display("FAIL write_hold c=%0d: got we=%b be=%b addr=%h wd=%h expected 1 0100 00000020 00aa0000", c, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o);
      end
    end
    n_checks++;
    if (m_ready_o !== 4'b0010 || m_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL write_done: got ready=%b err=%b expected 0010 0", m_ready_o, m_err_o);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    m_req_i[2]  = 1'b1;
    m_addr_i[2] = 32'h40;
    mem_rd_i    = 32'hDEADBEEF;
    for (int c = 1; c <= TO; c++) begin
      cyc();
      settle();
      n_checks++;
      if (c < TO) begin
        if (m_ready_o !== '0 || mem_req_o !== 1'b1 || m_err_o !== 1'b0) begin
          n_fail++;
          $display("FAIL timeout_wait c=%0d: got ready=%b req=%b err=%b expected 0000 1 0", c, m_ready_o, mem_req_o, m_err_o);
        end
      end else begin
        if (m_ready_o !== 4'b0100 || m_err_o !== 1'b1 || m_rd_o !== 32'h0) begin
          n_fail++;
          $display("FAIL timeout_fire: got ready=%b err=%b rd=%h expected 0100 1 00000000", m_ready_o, m_err_o, m_rd_o);
        end
      end
    end
    cyc();
    m_req_i     = '0;
    mem_ready_i = 1'b1;
    settle();
    n_checks++;
    if (busy_o !== 1'b0 || m_ready_o !== '0 || m_err_o !== 1'b0) begin
      n_fail++;
      $display("FAIL timeout_idle_ready: got busy=%b ready=%b err=%b expected 0 0000 0", busy_o, m_ready_o, m_err_o);
    end
    cyc();
    mem_ready_i = 1'b0;
    m_req_i[0]  = 1'b1;
    m_addr_i[0] = 32'h44;
    cyc();
    mem_ready_i = 1'b1;
    mem_rd_i    = 32'h55AA;
    settle();
    n_checks++;
    if (m_ready_o !== 4'b0001 || m_err_o !== 1'b0 || m_rd_o !== 32'h55AA || mem_addr_o !== 32'h44) begin
      n_fail++;
      $display("FAIL timeout_recover: got ready=%b err=%b rd=%h addr=%h expected 0001 0 000055aa 00000044", m_ready_o, m_err_o, m_rd_o, mem_addr_o);
    end
    cyc();
    idle_inputs();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    m_req_i[1]  = 1'b1;
    m_addr_i[1] = 32'h80;
    cyc();
    settle();
    n_checks++;
    if (busy_o !== 1'b1 || mem_req_o !== 1'b1) begin
      n_fail++;
      $display("FAIL rstbusy_pre: got busy=%b req=%b expected 1 1", busy_o, mem_req_o);
    end
    rst_ni      = 1'b0;
    mem_ready_i = 1'b1;
    #1;
    n_checks++;
    if (mem_req_o !== 1'b0 || busy_o !== 1'b0 || m_ready_o !== '0) begin
      n_fail++;
      $display("FAIL rstbusy_async: got req=%b busy=%b ready=%b expected 0 0 0000", mem_req_o, busy_o, m_ready_o);
    end
    cyc();
    idle_inputs();
    cyc();
    rst_ni      = 1'b1;
    m_req_i     = 4'b1001;
    m_addr_i[0] = 32'h100;
    m_addr_i[3] = 32'h300;
    cyc();
    settle();
    n_checks++;
    if (busy_o !== 1'b1 || mem_addr_o !== 32'h100) begin
      n_fail++;
      $display("FAIL rstbusy_first: got busy=%b addr=%h expected 1 00000100", busy_o, mem_addr_o);
    end
    idle_inputs();
    do_reset();
  endtask

  task automatic test_rr_skip();
    do_reset();
    m_req_i     = 4'b0010;
    m_addr_i[1] = 32'h11;
    m_addr_i[3] = 32'h33;
    mem_ready_i = 1'b1;
    cyc();
    settle();
    n_checks++;
    if (m_ready_o !== 4'b0010 || mem_addr_o !== 32'h11) begin
      n_fail++;
      $display("FAIL rr_first: got ready=%b addr=%h expected 0010 00000011", m_ready_o, mem_addr_o);
    end
    cyc();
    m_req_i = 4'b1010;
    cyc();
    settle();
    n_checks++;
    if (m_ready_o !== 4'b1000 || mem_addr_o !== 32'h33) begin
      n_fail++;
      $display("FAIL rr_skip3: got ready=%b addr=%h expected 1000 00000033", m_ready_o, mem_addr_o);
    end
    cyc();
    cyc();
    settle();
    n_checks++;
    if (m_ready_o !== 4'b0010 || mem_addr_o !== 32'h11) begin
      n_fail++;
      $display("FAIL rr_wrap1: got ready=%b addr=%h expected 0010 00000011", m_ready_o, mem_addr_o);
    end
    idle_inputs();
  endtask

  // Reference model: one outstanding transaction; winner is the nearest
  // requester after the previous winner in circular order.
  task automatic test_random();
    bit            mb;
    int            mg, mc, ml, idx;
    logic          mwe;
    logic [3:0]    mbe;
    logic [31:0]   maddr, mwd;
    logic [NM-1:0] served, er;
    bit            done;
    logic [31:0]   erd;
    do_reset();
    mb = 0; mg = 0; mc = 0; ml = NM - 1;
    mwe = 0; mbe = '0; maddr = '0; mwd = '0;
    served = '0;
    for (int t = 0; t < 400; t++) begin
      cyc();
      for (int i = 0; i < NM; i++) begin
        if (served[i]) m_req_i[i] = 1'b0;
        if (!m_req_i[i] && $urandom_range(0, 2) == 0) begin
          m_req_i[i]  = 1'b1;
          m_we_i[i]   = 1'($urandom_range(0, 1));
          m_be_i[i]   = 4'($urandom);
          m_addr_i[i] = $urandom;
          m_wd_i[i]   = $urandom;
        end
      end
      served = '0;
      if (mb && $urandom_range(0, 3) == 0) begin
        m_addr_i[mg] = $urandom;
        m_wd_i[mg]   = $urandom;
      end
      mem_rd_i    = $urandom;
      mem_ready_i = mb ? ($urandom_range(0, 9) < 4) : 1'($urandom_range(0, 1));
      settle();

      done = mb && (mem_ready_i || mc == TO - 1);
      er   = '0;
      if (done) er[mg] = 1'b1;
      erd  = (done && mem_ready_i) ? mem_rd_i : 32'h0;
      n_checks++;
      if ({mem_req_o, busy_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o} !==
          (mb ? {1'b1, 1'b1, mwe, mbe, maddr, mwd} : 71'h0)) begin
        n_fail++;
        $display("FAIL rnd_mem t=%0d: got req=%b we=%b be=%b addr=%h wd=%h expected req=%b we=%b be=%b addr=%h wd=%h",
                 t, mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o, mb, mwe, mbe, maddr, mwd);
      end
      n_checks++;
      if (m_ready_o !== er || m_err_o !== (done && !mem_ready_i) || m_rd_o !== erd) begin
        n_fail++;
        $display("FAIL rnd_cpl t=%0d: got ready=%b err=%b rd=%h expected ready=%b err=%b rd=%h",
                 t, m_ready_o, m_err_o, m_rd_o, er, (done && !mem_ready_i), erd);
      end

      if (mb) begin
        if (done) begin
          mb = 0;
          served[mg] = 1'b1;
        end else begin
          mc++;
        end
      end else if (m_req_i != '0) begin
        for (int k = 1; k <= NM; k++) begin
          idx = (ml + k) % NM;
          if (m_req_i[idx]) begin
            mg = idx;
            break;
          end
        end
        ml    = mg;
        mb    = 1;
        mc    = 0;
        mwe   = m_we_i[mg];
        mbe   = m_be_i[mg];
        maddr = m_addr_i[mg];
        mwd   = m_wd_i[mg];
      end
    end
    idle_inputs();
  endtask

  initial begin
    rst_ni = 1'b0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_back_to_back();
    test_write_hold();
    test_timeout();
    test_reset_mid_busy();
    test_rr_skip();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one data-memory port (req/we/be/addr/wd/rd/ready) between N requesters, e.g. the core LSU and a DMA/debug master. Round-robin arbitration; the winner's request is latched and held stable on the memory side until the memory answers or a watchdog expires. Sits between the requesters' LSU-style memory interfaces and the data memory / bus.

Parameters:
N_MASTERS, 2, number of requesters (2..8)
TIMEOUT, 255, max BUSY cycles waiting for mem_ready_i before forced error completion (1..65535)

Ports:
clk_i  in  1  clock
rst_ni  in  1  asynchronous active-low reset
m_req_i  in  N_MASTERS  per-master request, held until its m_ready_o
m_we_i  in  N_MASTERS  per-master write enable
m_be_i  in  N_MASTERSx4  per-master byte enables
m_addr_i  in  N_MASTERSx32  per-master address
m_wd_i  in  N_MASTERSx32  per-master write data
m_rd_o  out  32  read data, shared; valid only with m_ready_o
m_ready_o  out  N_MASTERS  one-hot completion strobe
m_err_o  out  1  completion was a timeout; valid only with m_ready_o
mem_req_o  out  1  memory request
mem_we_o  out  1  memory write enable
mem_be_o  out  4  memory byte enables
mem_addr_o  out  32  memory address
mem_wd_o  out  32  memory write data
mem_rd_i  in  32  memory read data, valid with mem_ready_i
mem_ready_i  in  1  memory completion strobe
busy_o  out  1  transaction in flight (state BUSY)

Behaviour:
- Clock clk_i; reset rst_ni asynchronous, active-low. On reset: state IDLE, last_grant = N_MASTERS-1 (master 0 wins first), timeout counter 0, latched request regs 0; all outputs 0.
- States: IDLE, BUSY.
- IDLE: if |m_req_i, round-robin pick: first requesting index after last_grant, wrapping. At the clock edge: latch winner's we/be/addr/wd, grant <= winner, last_grant <= winner, counter <= 0, -> BUSY. No request -> stay IDLE.
- BUSY: mem_req_o=1; mem_we/be/addr/wd driven from latched regs only, never from live inputs. busy_o=1.
- BUSY & mem_ready_i: m_ready_o[grant]=1 combinationally in the same cycle; m_rd_o=mem_rd_i; m_err_o=0; -> IDLE.
- BUSY & !mem_ready_i & counter==TIMEOUT-1: m_ready_o[grant]=1, m_rd_o=32'h0, m_err_o=1, -> IDLE. Otherwise counter++.
- Latency: request seen at edge N -> mem_req_o high in cycle N+1; best-case completion in cycle N+1; one IDLE cycle between back-to-back transactions, so max throughput is 1 per 2 cycles.
- Outside completion cycles: m_ready_o=0, m_err_o=0, m_rd_o=0. mem_we/be/addr/wd are 0 in IDLE.
- A master deasserting m_req_i mid-transaction is ignored; the transaction completes normally.
- mem_ready_i in IDLE is ignored.
- Round-robin is fair: with all masters requesting continuously, each is served once per N_MASTERS transactions.
- Counter width $clog2(TIMEOUT+1); no wrap possible.
- Reset asserted mid-BUSY: immediate return to IDLE, mem_req_o drops asynchronously, no m_ready_o pulse.

Decomposition:
- Package mem_arb_pkg: state enum (ARB_IDLE, ARB_BUSY); constant ARB_ERR_RDATA = 32'h0.
- Sub-module rr_arbiter: combinational round-robin picker. Inputs: request vector, last_grant index. Outputs: winner index, valid.

Test Plan:
- Single master 0 read at addr 0x100, memory returns 0xCAFEBABE with ready 2 cycles after mem_req_o -> mem_addr_o=0x100 from cycle N+1; m_ready_o=01 with m_rd_o=0xCAFEBABE and m_err_o=0 in cycle N+3.
- Both masters request continuously, memory ready same cycle -> grants alternate 0,1,0,1; each m_ready_o pulse 1 cycle; IDLE cycle between grants.
- Master 1 write addr 0x20, be=4'b0100, wd=0x00AA0000; master 1 changes addr to 0x99 while BUSY -> mem side still shows 0x20/0100/0x00AA0000 until ready.
- TIMEOUT=4, memory never ready -> after exactly 4 BUSY cycles m_ready_o[grant]=1, m_err_o=1, m_rd_o=0; next request is served normally.
- rst_ni pulled low mid-BUSY -> mem_req_o, busy_o, m_ready_o go 0 without a clock edge; after release, first grant goes to master 0.
- N_MASTERS=4, requests from masters 1 and 3 only, last_grant=1 -> master 3 granted, then master 1.
